// File: rtl/interface_fsm.sv
// interface_fsm: 4-phase request/acknowledge sequencer wrapped around one core operation, with busy timeout
// Ports: clk, nrst (async active-low) | input_request (host pin, pre-synchronized)
//        op_done, op_result[7:0], op_result_valid (core completion pulse and result)
//        fsm_state (I_IDLE/I_BUSY/I_ACK), input_ack, output_byte[7:0], output_valid, timeout_err
package interface_fsm_pkg;
    typedef logic [1:0] interface_state_t;
    localparam interface_state_t I_IDLE = 2'd0;
    localparam interface_state_t I_BUSY = 2'd1;
    localparam interface_state_t I_ACK  = 2'd2;
endpackage

module interface_fsm
    import interface_fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             input_request,
    input  logic             op_done,
    input  logic [7:0]       op_result,
    input  logic             op_result_valid,
    output interface_state_t fsm_state,
    output logic             input_ack,
    output logic [7:0]       output_byte,
    output logic             output_valid,
    output logic             timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    interface_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ack;
    logic [7:0]       r_byte;
    logic             r_valid;
    logic             r_terr;
    logic             w_timeout;
    interface_state_t w_next;

    assign w_timeout = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);

    // Leaving I_ACK needs request low, so a held request cannot retrigger.
    assign w_next = (r_state == I_IDLE) ? (input_request ? I_BUSY : I_IDLE)
                  : (r_state == I_BUSY) ? ((op_done || w_timeout) ? I_ACK : I_BUSY)
                  : (r_state == I_ACK)  ? (input_request ? I_ACK : I_IDLE)
                  : I_IDLE;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= I_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Ack tracks the next state so it is high exactly while in I_ACK.
            r_ack   <= w_next == I_ACK;
            if (r_state == I_IDLE && input_request) begin
                r_cnt   <= '0;
                r_terr  <= 1'b0;
                r_valid <= 1'b0;
            end
            if (r_state == I_BUSY) begin
                if (!w_timeout)
                    r_cnt <= r_cnt + CNT_W'(1);
                // Completion beats timeout when both land on the same edge.
                if (op_done) begin
                    if (op_result_valid) begin
                        r_byte  <= op_result;
                        r_valid <= 1'b1;
                    end
                end else if (w_timeout) begin
                    r_terr <= 1'b1;
                end
            end
        end
    end

    assign fsm_state    = r_state;
    assign input_ack    = r_ack;
    assign output_byte  = r_byte;
    assign output_valid = r_valid;
    assign timeout_err  = r_terr;
endmodule

// File: tb/tb_interface_fsm.sv
// tb_interface_fsm: directed self-checking bench for interface_fsm with TIMEOUT_CYCLES=4
module tb_interface_fsm;
    import interface_fsm_pkg::*;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             input_request = 1'b0;
    logic             op_done = 1'b0;
    logic [7:0]       op_result = 8'h00;
    logic             op_result_valid = 1'b0;
    interface_state_t fsm_state;
    logic             input_ack;
    logic [7:0]       output_byte;
    logic             output_valid;
    logic             timeout_err;
    int               checks = 0;
    int               failures = 0;

    interface_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .nrst(nrst),
        .input_request(input_request),
        .op_done(op_done),
        .op_result(op_result),
        .op_result_valid(op_result_valid),
        .fsm_state(fsm_state),
        .input_ack(input_ack),
        .output_byte(output_byte),
        .output_valid(output_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input interface_state_t st, input logic ack,
                           input logic [7:0] b, input logic v, input logic te);
        chk({tag, ".state"}, 16'(fsm_state), 16'(st));
        chk({tag, ".ack"}, 16'(input_ack), 16'(ack));
        chk({tag, ".byte"}, 16'(output_byte), 16'(b));
        chk({tag, ".valid"}, 16'(output_valid), 16'(v));
        chk({tag, ".terr"}, 16'(timeout_err), 16'(te));
    endtask

    initial begin
        #3;
        chk_all("reset", I_IDLE, 0, 8'h00, 0, 0);
        step();
        step();
        nrst = 1'b1;
        step();
        chk_all("idle", I_IDLE, 0, 8'h00, 0, 0);

        // key load: no valid result, byte keeps its reset value
        input_request = 1'b1;
        step();
        chk_all("kl.busy", I_BUSY, 0, 8'h00, 0, 0);
        op_done = 1'b1; op_result = 8'hFF; op_result_valid = 1'b0;
        step();
        op_done = 1'b0;
        chk_all("kl.ack", I_ACK, 1, 8'h00, 0, 0);
        input_request = 1'b0;
        step();
        chk_all("kl.idle", I_IDLE, 0, 8'h00, 0, 0);

        // basic cipher byte
        input_request = 1'b1;
        step();
        chk_all("basic.busy", I_BUSY, 0, 8'h00, 0, 0);
        op_done = 1'b1; op_result = 8'hA5; op_result_valid = 1'b1;
        step();
        op_done = 1'b0; op_result_valid = 1'b0;
        chk_all("basic.ack", I_ACK, 1, 8'hA5, 1, 0);
        input_request = 1'b0;
        step();
        chk_all("basic.idle", I_IDLE, 0, 8'hA5, 1, 0);

        // op_done in idle ignored
        op_done = 1'b1; op_result = 8'h77; op_result_valid = 1'b1;
        step();
        op_done = 1'b0; op_result_valid = 1'b0;
        chk_all("idle.opdone", I_IDLE, 0, 8'hA5, 1, 0);

        // timeout: exactly 4 cycles in I_BUSY
        input_request = 1'b1;
        step();
        chk_all("to.busy0", I_BUSY, 0, 8'hA5, 0, 0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("to.busy", 16'(fsm_state), 16'(I_BUSY));
        end
        step();
        chk_all("to.ack", I_ACK, 1, 8'hA5, 0, 1);
        step();
        chk_all("to.hold", I_ACK, 1, 8'hA5, 0, 1);
        input_request = 1'b0;
        step();
        chk_all("to.idle", I_IDLE, 0, 8'hA5, 0, 1);

        // next request clears timeout_err; op_done coincides with timeout edge
        input_request = 1'b1;
        step();
        chk_all("sim.busy", I_BUSY, 0, 8'hA5, 0, 0);
        step();
        step();
        step();
        chk("sim.busy3", 16'(fsm_state), 16'(I_BUSY));
        op_done = 1'b1; op_result = 8'h3C; op_result_valid = 1'b1;
        step();
        chk_all("sim.ack", I_ACK, 1, 8'h3C, 1, 0);
        op_result = 8'h11;
        step();
        op_done = 1'b0; op_result_valid = 1'b0;
        chk_all("ack.opdone", I_ACK, 1, 8'h3C, 1, 0);
        input_request = 1'b0;
        step();
        chk_all("sim.idle", I_IDLE, 0, 8'h3C, 1, 0);

        // early request release
        input_request = 1'b1;
        step();
        input_request = 1'b0;
        step();
        chk("early.busy1", 16'(fsm_state), 16'(I_BUSY));
        step();
        chk("early.busy2", 16'(fsm_state), 16'(I_BUSY));
        op_done = 1'b1; op_result = 8'h42; op_result_valid = 1'b1;
        step();
        op_done = 1'b0; op_result_valid = 1'b0;
        chk_all("early.ack", I_ACK, 1, 8'h42, 1, 0);
        step();
        chk_all("early.idle", I_IDLE, 0, 8'h42, 1, 0);
        step();
        chk("early.stay", 16'(fsm_state), 16'(I_IDLE));

        // async reset mid-I_ACK
        input_request = 1'b1;
        step();
        op_done = 1'b1; op_result = 8'h5A; op_result_valid = 1'b1;
        step();
        op_done = 1'b0; op_result_valid = 1'b0;
        chk_all("rst.ack", I_ACK, 1, 8'h5A, 1, 0);
        #2;
        nrst = 1'b0;
        #1;
        chk_all("rst.async", I_IDLE, 0, 8'h00, 0, 0);
        input_request = 1'b0;
        step();
        nrst = 1'b1;
        step();
        chk_all("rst.after", I_IDLE, 0, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
